// File: rtl/axi_reg_cfg.sv
// axi_reg_cfg: AXI4 register slice between an application master port and
// the shell interconnect. Each channel is either a small circular buffer or a
// plain wire-through. New AW/AR admission is gated by outstanding-burst limits
// and by a quiesce request; idle reports a fully drained, quiesced port.

// One AXI channel stage: 2^LD-entry circular buffer, or a wire when BYP is set.
module axi_reg_cfg_chan #(
  parameter int W   = 8,
  parameter int LD  = 1,
  parameter bit BYP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_empty
);

  if (BYP) begin : g_byp
    // Zero-latency pass-through; handshakes are still held off during reset.
    assign o_valid = !rst && i_valid;
    assign o_ready = !rst && i_ready;
    assign o_data  = i_data;
    assign o_empty = 1'b1;
  end else begin : g_buf
    localparam int DEPTH = 1 << LD;
    // Depth 1 still needs a one-bit pointer; it simply never leaves zero.
    localparam int PW    = (LD > 0) ? LD : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LD:0]   r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_ready = !rst && (r_count != (LD+1)'(DEPTH));
    assign o_valid = !rst && (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    // Payload storage; only accepted beats are written.
    // NOTE: the storage array is deliberately not reset: the zeroed count
    // already marks every entry invalid, and a reset here would turn cheap
    // RAM into a wide bank of resettable flops.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

module axi_reg_cfg #(
  parameter int         AW_LD      = 1,
  parameter int         W_LD       = 1,
  parameter int         B_LD       = 1,
  parameter int         AR_LD      = 1,
  parameter int         R_LD       = 1,
  parameter logic [4:0] BYPASS     = 5'b00000,
  parameter int         MAX_WR_OUT = 16,
  parameter int         MAX_RD_OUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  // upstream (application master) side
  input  logic         i_s_awvalid,
  output logic         o_s_awready,
  input  logic [15:0]  i_s_awid,
  input  logic [63:0]  i_s_awaddr,
  input  logic [7:0]   i_s_awlen,
  input  logic [2:0]   i_s_awsize,
  input  logic         i_s_wvalid,
  output logic         o_s_wready,
  input  logic [511:0] i_s_wdata,
  input  logic [63:0]  i_s_wstrb,
  input  logic         i_s_wlast,
  output logic         o_s_bvalid,
  input  logic         i_s_bready,
  output logic [15:0]  o_s_bid,
  output logic [1:0]   o_s_bresp,
  input  logic         i_s_arvalid,
  output logic         o_s_arready,
  input  logic [15:0]  i_s_arid,
  input  logic [63:0]  i_s_araddr,
  input  logic [7:0]   i_s_arlen,
  input  logic [2:0]   i_s_arsize,
  output logic         o_s_rvalid,
  input  logic         i_s_rready,
  output logic [15:0]  o_s_rid,
  output logic [511:0] o_s_rdata,
  output logic [1:0]   o_s_rresp,
  output logic         o_s_rlast,
  output logic         o_s_ruser,
  // downstream (interconnect) side
  output logic         o_m_awvalid,
  input  logic         i_m_awready,
  output logic [15:0]  o_m_awid,
  output logic [63:0]  o_m_awaddr,
  output logic [7:0]   o_m_awlen,
  output logic [2:0]   o_m_awsize,
  output logic         o_m_wvalid,
  input  logic         i_m_wready,
  output logic [511:0] o_m_wdata,
  output logic [63:0]  o_m_wstrb,
  output logic         o_m_wlast,
  input  logic         i_m_bvalid,
  output logic         o_m_bready,
  input  logic [15:0]  i_m_bid,
  input  logic [1:0]   i_m_bresp,
  output logic         o_m_arvalid,
  input  logic         i_m_arready,
  output logic [15:0]  o_m_arid,
  output logic [63:0]  o_m_araddr,
  output logic [7:0]   o_m_arlen,
  output logic [2:0]   o_m_arsize,
  input  logic         i_m_rvalid,
  output logic         o_m_rready,
  input  logic [15:0]  i_m_rid,
  input  logic [511:0] i_m_rdata,
  input  logic [1:0]   i_m_rresp,
  input  logic         i_m_rlast,
  input  logic         i_m_ruser,
  // control / status
  input  logic         i_quiesce,
  output logic         o_idle,
  output logic [7:0]   o_wr_out,
  output logic [7:0]   o_rd_out,
  output logic         o_err
);

  localparam int AXW = 16 + 64 + 8 + 3;    // id, addr, len, size
  localparam int WW  = 512 + 64 + 1;       // data, strb, last
  localparam int BW  = 16 + 2;             // id, resp
  localparam int RW  = 16 + 512 + 2 + 1 + 1; // id, data, resp, last, user

  logic [7:0] r_wr_out;
  logic [7:0] r_rd_out;
  logic       r_err;
  logic       r_idle;

  logic w_aw_gate, w_ar_gate;
  logic w_aw_in_ready, w_ar_in_ready;
  logic w_aw_empty, w_w_empty, w_b_empty, w_ar_empty, w_r_empty;
  logic w_wr_inc, w_wr_dec, w_rd_inc, w_rd_dec;
  logic w_wr_uf, w_rd_uf;

  // Admission gate: the same term masks the input valid so a gated beat is
  // neither buffered nor, in bypass mode, passed downstream.
  assign w_aw_gate   = !i_quiesce && (r_wr_out < 8'(MAX_WR_OUT));
  assign w_ar_gate   = !i_quiesce && (r_rd_out < 8'(MAX_RD_OUT));
  assign o_s_awready = w_aw_in_ready && w_aw_gate;
  assign o_s_arready = w_ar_in_ready && w_ar_gate;

  axi_reg_cfg_chan #(.W(AXW), .LD(AW_LD), .BYP(BYPASS[4])) u_aw (
    .clk(clk), .rst(rst),
    .i_valid(i_s_awvalid && w_aw_gate), .o_ready(w_aw_in_ready),
    .i_data({i_s_awid, i_s_awaddr, i_s_awlen, i_s_awsize}),
    .o_valid(o_m_awvalid), .i_ready(i_m_awready),
    .o_data({o_m_awid, o_m_awaddr, o_m_awlen, o_m_awsize}),
    .o_empty(w_aw_empty)
  );

  axi_reg_cfg_chan #(.W(WW), .LD(W_LD), .BYP(BYPASS[3])) u_w (
    .clk(clk), .rst(rst),
    .i_valid(i_s_wvalid), .o_ready(o_s_wready),
    .i_data({i_s_wdata, i_s_wstrb, i_s_wlast}),
    .o_valid(o_m_wvalid), .i_ready(i_m_wready),
    .o_data({o_m_wdata, o_m_wstrb, o_m_wlast}),
    .o_empty(w_w_empty)
  );

  axi_reg_cfg_chan #(.W(BW), .LD(B_LD), .BYP(BYPASS[2])) u_b (
    .clk(clk), .rst(rst),
    .i_valid(i_m_bvalid), .o_ready(o_m_bready),
    .i_data({i_m_bid, i_m_bresp}),
    .o_valid(o_s_bvalid), .i_ready(i_s_bready),
    .o_data({o_s_bid, o_s_bresp}),
    .o_empty(w_b_empty)
  );

  axi_reg_cfg_chan #(.W(AXW), .LD(AR_LD), .BYP(BYPASS[1])) u_ar (
    .clk(clk), .rst(rst),
    .i_valid(i_s_arvalid && w_ar_gate), .o_ready(w_ar_in_ready),
    .i_data({i_s_arid, i_s_araddr, i_s_arlen, i_s_arsize}),
    .o_valid(o_m_arvalid), .i_ready(i_m_arready),
    .o_data({o_m_arid, o_m_araddr, o_m_arlen, o_m_arsize}),
    .o_empty(w_ar_empty)
  );

  axi_reg_cfg_chan #(.W(RW), .LD(R_LD), .BYP(BYPASS[0])) u_r (
    .clk(clk), .rst(rst),
    .i_valid(i_m_rvalid), .o_ready(o_m_rready),
    .i_data({i_m_rid, i_m_rdata, i_m_rresp, i_m_rlast, i_m_ruser}),
    .o_valid(o_s_rvalid), .i_ready(i_s_rready),
    .o_data({o_s_rid, o_s_rdata, o_s_rresp, o_s_rlast, o_s_ruser}),
    .o_empty(w_r_empty)
  );

  // Counter events are all taken at the upstream boundary.
  assign w_wr_inc = i_s_awvalid && o_s_awready;
  assign w_wr_dec = o_s_bvalid && i_s_bready;
  assign w_rd_inc = i_s_arvalid && o_s_arready;
  assign w_rd_dec = o_s_rvalid && i_s_rready && o_s_rlast;
  assign w_wr_uf  = w_wr_dec && !w_wr_inc && (r_wr_out == '0);
  assign w_rd_uf  = w_rd_dec && !w_rd_inc && (r_rd_out == '0);

  // Outstanding write bursts; an underflowing decrement holds at zero.
  always_ff @(posedge clk) begin
    if (rst)                                      r_wr_out <= '0;
    else if (w_wr_inc && !w_wr_dec)               r_wr_out <= r_wr_out + 8'd1;
    else if (w_wr_dec && !w_wr_inc && !w_wr_uf)   r_wr_out <= r_wr_out - 8'd1;
  end

  // Outstanding read bursts; only the last beat of a burst retires it.
  always_ff @(posedge clk) begin
    if (rst)                                      r_rd_out <= '0;
    else if (w_rd_inc && !w_rd_dec)               r_rd_out <= r_rd_out + 8'd1;
    else if (w_rd_dec && !w_rd_inc && !w_rd_uf)   r_rd_out <= r_rd_out - 8'd1;
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                     r_err <= 1'b0;
    else if (w_wr_uf || w_rd_uf) r_err <= 1'b1;
  end

  // Registered drain status for the OS layer.
  always_ff @(posedge clk) begin
    if (rst) r_idle <= 1'b0;
    else     r_idle <= i_quiesce && (r_wr_out == '0) && (r_rd_out == '0) &&
                       w_aw_empty && w_w_empty && w_b_empty &&
                       w_ar_empty && w_r_empty;
  end

  assign o_wr_out = r_wr_out;
  assign o_rd_out = r_rd_out;
  assign o_err    = r_err;
  assign o_idle   = r_idle;

endmodule
